dense_core_param: RTL and testbench
===================================

// Module: dense_core_param
// PURPOSE
//  Parametrised row-stationary conv core, successor to the fixed 32-row/3-PE dense core.
//  Streams K weights and one activation row segment per pass over valid/ready.
//  Accumulates NUM_ROWS signed output lanes over NUM_PASS passes (passes = K x input channels),
//  with runtime K and stride. Returns lanes on a valid/ready psum port and pulses core_done.
// PARAMETERS
//  INPUT_BW   8   activation/weight width, signed two's complement
//  PSUM_BW    32  accumulator and output lane width
//  NUM_ROWS   32  output lanes (output pixels along W), one MAC per lane
//  K_MAX      3   largest supported kernel width
//  STRIDE_MAX 2   largest supported stride
//  PASS_W     12  width of NUM_PASS (max 4095 passes)
//  ACT_DEPTH  (NUM_ROWS-1)*STRIDE_MAX+K_MAX   internal activation buffer depth (65 at defaults)
// PORTS
//  clk        in   1                  clock
//  resetn     in   1                  async active-low reset
//  core_start in   1                  1-cycle start; config sampled this cycle
//  K          in   3                  kernel width, 1..K_MAX
//  STRIDE     in   2                  stride, 1..STRIDE_MAX
//  NUM_PASS   in   PASS_W             passes to accumulate, >=1
//  core_busy  out  1                  high from accepted start until cycle after core_done
//  core_done  out  1                  1-cycle pulse at end of job (normal or error)
//  err_cfg    out  1                  1-cycle pulse with core_done on illegal config
//  w_valid    in   1                  weight stream valid
//  w_ready    out  1                  weight stream ready
//  w_data     in   INPUT_BW           weight, kx order 0..K-1
//  act_valid  in   1                  activation stream valid
//  act_ready  out  1                  activation stream ready
//  act_data   in   INPUT_BW           activation, x order 0..ACT_LEN-1
//  psum_valid out  1                  result valid
//  psum_ready in   1                  result accepted
//  psum_rows  out  PSUM_BW*NUM_ROWS   lane j at [j*PSUM_BW +: PSUM_BW]
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE; all outputs 0; accumulators, buffers, counters cleared.
//  FSM: IDLE -> LOAD_W -> LOAD_A -> COMPUTE -> (LOAD_W | OUT) -> IDLE.
//  IDLE: core_start latches K/STRIDE/NUM_PASS, clears accumulators and pass count.
//   Illegal config (K=0, K>K_MAX, STRIDE=0, STRIDE>STRIDE_MAX, NUM_PASS=0):
//   next cycle core_done=err_cfg=1, stay IDLE, no stream accepted, accumulators untouched.
//  core_start outside IDLE is ignored; config inputs are don't-care after the start cycle.
//  LOAD_W: w_ready=1, others 0; each w_valid&w_ready writes wbuf[kcnt]; after K-th -> LOAD_A.
//  LOAD_A: act_ready=1; ACT_LEN=(NUM_ROWS-1)*STRIDE+K beats into abuf[0..ACT_LEN-1] -> COMPUTE.
//  Bubbles on valid are allowed; no beat lost or duplicated. Only one ready high at a time.
//  COMPUTE: exactly K cycles, kx=0..K-1; every lane j: acc[j] += abuf[j*STRIDE+kx]*wbuf[kx].
//   Product is 2*INPUT_BW signed, sign-extended to PSUM_BW; sum wraps mod 2^PSUM_BW (no saturation).
//  After COMPUTE: pass_cnt+1 < NUM_PASS -> LOAD_W, else OUT.
//  OUT: psum_valid=1, psum_rows=acc, both held stable until psum_ready.
//   On handshake: core_done=1 for one cycle (next cycle), -> IDLE; psum_rows keeps last value.
//  Latency, no stalls: per pass K + ACT_LEN + K cycles (K=3,S=1,NUM_ROWS=32: 3+34+3=40).
//   First psum_valid = 1 + NUM_PASS*(2K+ACT_LEN) cycles after core_start.
//  core_busy: 1 from cycle after accepted start through the core_done cycle.
//  Reset mid-operation: immediate abort to IDLE, no done pulse; ready/valid drop asynchronously.
// TESTING
//  T1 K=1,S=1,NUM_PASS=1, w=2, act[x]=x: lane j = 2j; psum_valid at cycle 1+34 after start.
//  T2 K=3,S=1,NUM_PASS=3, all w=1, all act=1: every lane = 9; 120 cycles of stream then OUT.
//  T3 K=3,S=2,NUM_PASS=1, w={1,0,-1}, act[x]=x: ACT_LEN=65 beats; every lane = -2.
//  T4 K=1, w=-128, act=-128, NUM_PASS=2: lanes = 32768; PSUM_BW=16 build wraps to -32768.
//  T5 random valid gaps on both streams, psum_ready low 10 cycles: psum_rows stable, done only after handshake.
//  T6 K=0 start -> err_cfg & core_done next cycle, w_ready/act_ready never 1.
//  T7 resetn low during LOAD_A -> all outputs 0; a new T2 job afterwards returns 9 on every lane.

Source files
------------

// File: rtl/dense_core_param.sv
// Parametrised row-stationary conv core: streams K weights plus one activation row segment per
// pass, accumulates NUM_ROWS signed lanes over NUM_PASS passes, and returns them on a psum port.
module dense_core_param #(
  parameter int unsigned INPUT_BW   = 8,
  parameter int unsigned PSUM_BW    = 32,
  parameter int unsigned NUM_ROWS   = 32,
  parameter int unsigned K_MAX      = 3,
  parameter int unsigned STRIDE_MAX = 2,
  parameter int unsigned PASS_W     = 12,
  parameter int unsigned ACT_DEPTH  = (NUM_ROWS - 1) * STRIDE_MAX + K_MAX
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        core_start,
  input  logic [2:0]                  K,
  input  logic [1:0]                  STRIDE,
  input  logic [PASS_W-1:0]           NUM_PASS,
  output logic                        core_busy,
  output logic                        core_done,
  output logic                        err_cfg,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [INPUT_BW-1:0]         w_data,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic [INPUT_BW-1:0]         act_data,
  output logic                        psum_valid,
  input  logic                        psum_ready,
  output logic [PSUM_BW*NUM_ROWS-1:0] psum_rows
);

  localparam int unsigned AW = $clog2(ACT_DEPTH);
  localparam int unsigned KW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  typedef enum logic [2:0] {StIdle, StLoadW, StLoadA, StCompute, StOut} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  k_q;
  logic [1:0]                  stride_q;
  logic [PASS_W-1:0]           num_pass_q, pass_cnt_q;
  logic [KW-1:0]               kcnt_q;
  logic [AW-1:0]               acnt_q;
  logic signed [INPUT_BW-1:0]  wbuf_q [K_MAX];
  logic signed [INPUT_BW-1:0]  abuf_q [ACT_DEPTH];
  logic signed [PSUM_BW-1:0]   acc_q [NUM_ROWS];
  logic                        done_q, err_q;

  logic                        cfg_ok, w_hs, a_hs, k_last, act_last, pass_last;
  logic [AW-1:0]               act_last_idx;
  logic signed [2*INPUT_BW-1:0] prod [NUM_ROWS];

  assign cfg_ok = (K != 3'd0) && (32'(K) <= K_MAX) && (STRIDE != 2'd0) &&
                  (32'(STRIDE) <= STRIDE_MAX) && (NUM_PASS != '0);
  assign w_hs         = w_valid & w_ready;
  assign a_hs         = act_valid & act_ready;
  assign k_last       = (kcnt_q == KW'(k_q - 3'd1));
  assign act_last_idx = AW'((NUM_ROWS - 1) * 32'(stride_q) + 32'(k_q) - 32'd1);
  assign act_last     = (acnt_q == act_last_idx);
  assign pass_last    = ((pass_cnt_q + PASS_W'(1)) == num_pass_q);

  // One MAC per lane; kcnt_q doubles as the kernel tap index during compute.
  always_comb begin
    for (int j = 0; j < NUM_ROWS; j++) begin
      prod[j] = abuf_q[AW'(j * 32'(stride_q) + 32'(kcnt_q))] * wbuf_q[kcnt_q];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (core_start && cfg_ok) state_d = StLoadW;
      StLoadW:   if (w_hs && k_last) state_d = StLoadA;
      StLoadA:   if (a_hs && act_last) state_d = StCompute;
      StCompute: if (k_last) state_d = pass_last ? StOut : StLoadW;
      StOut:     if (psum_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ready    = (state_q == StLoadW);
    act_ready  = (state_q == StLoadA);
    psum_valid = (state_q == StOut);
    core_busy  = (state_q != StIdle) | done_q;
    core_done  = done_q;
    err_cfg    = err_q;
    for (int j = 0; j < NUM_ROWS; j++) psum_rows[j*PSUM_BW +: PSUM_BW] = acc_q[j];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k_q        <= '0;
      stride_q   <= '0;
      num_pass_q <= '0;
      pass_cnt_q <= '0;
      kcnt_q     <= '0;
      acnt_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < K_MAX; i++)     wbuf_q[i] <= '0;
      for (int i = 0; i < ACT_DEPTH; i++) abuf_q[i] <= '0;
      for (int j = 0; j < NUM_ROWS; j++)  acc_q[j]  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (core_start) begin
            if (cfg_ok) begin
              k_q        <= K;
              stride_q   <= STRIDE;
              num_pass_q <= NUM_PASS;
              pass_cnt_q <= '0;
              kcnt_q     <= '0;
              acnt_q     <= '0;
              for (int j = 0; j < NUM_ROWS; j++) acc_q[j] <= '0;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        StLoadW: begin
          if (w_hs) begin
            wbuf_q[kcnt_q] <= w_data;
            kcnt_q         <= k_last ? '0 : kcnt_q + KW'(1);
          end
        end
        StLoadA: begin
          if (a_hs) begin
            abuf_q[acnt_q] <= act_data;
            acnt_q         <= act_last ? '0 : acnt_q + AW'(1);
          end
        end
        StCompute: begin
          // Product is sign-extended into the lane; the sum wraps at PSUM_BW.
          for (int j = 0; j < NUM_ROWS; j++) acc_q[j] <= acc_q[j] + PSUM_BW'(prod[j]);
          kcnt_q <= k_last ? '0 : kcnt_q + KW'(1);
          if (k_last) pass_cnt_q <= pass_cnt_q + PASS_W'(1);
        end
        StOut: begin
          if (psum_ready) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_core_param.sv
// Self-checking bench for dense_core_param: directed and randomized jobs scored against a
// plain-arithmetic convolution model.
module tb_dense_core_param;
  localparam int INPUT_BW = 8, PSUM_BW = 32, NUM_ROWS = 32, K_MAX = 3, STRIDE_MAX = 2;
  localparam int PASS_W = 12, ACT_DEPTH = 65, MAXP = 4;

  logic                        clk = 1'b0;
  logic                        resetn, core_start;
  logic [2:0]                  K;
  logic [1:0]                  STRIDE;
  logic [PASS_W-1:0]           NUM_PASS;
  logic                        core_busy, core_done, err_cfg;
  logic                        w_valid, w_ready, act_valid, act_ready, psum_valid, psum_ready;
  logic [INPUT_BW-1:0]         w_data, act_data;
  logic [PSUM_BW*NUM_ROWS-1:0] psum_rows;

  dense_core_param #(
    .INPUT_BW(INPUT_BW), .PSUM_BW(PSUM_BW), .NUM_ROWS(NUM_ROWS), .K_MAX(K_MAX),
    .STRIDE_MAX(STRIDE_MAX), .PASS_W(PASS_W)
  ) dut (
    .clk(clk), .resetn(resetn), .core_start(core_start), .K(K), .STRIDE(STRIDE),
    .NUM_PASS(NUM_PASS), .core_busy(core_busy), .core_done(core_done), .err_cfg(err_cfg),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .act_valid(act_valid),
    .act_ready(act_ready), .act_data(act_data), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .psum_rows(psum_rows)
  );

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, errors = 0, overlap = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (w_ready && act_ready) overlap <= overlap + 1;

  logic signed [7:0]  wq [MAXP][K_MAX];
  logic signed [7:0]  aq [MAXP][ACT_DEPTH];
  logic [PSUM_BW-1:0] expv [NUM_ROWS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PSUM_BW-1:0] lane(input int j);
    return psum_rows[j*PSUM_BW +: PSUM_BW];
  endfunction

  // out[j] = sum over passes and taps of act[j*S+kx]*w[kx], wrapped to PSUM_BW bits.
  function automatic void model(input int k, input int s, input int np);
    for (int j = 0; j < NUM_ROWS; j++) begin
      longint sum = 0;
      for (int p = 0; p < np; p++)
        for (int kx = 0; kx < k; kx++)
          sum += longint'(aq[p][j*s+kx]) * longint'(wq[p][kx]);
      expv[j] = sum[PSUM_BW-1:0];
    end
  endfunction

  task automatic send(input bit is_w, input logic [7:0] d, input int gap);
    int n = 0;
    repeat (gap) step();
    if (is_w) begin w_valid = 1'b1; w_data = d; end
    else      begin act_valid = 1'b1; act_data = d; end
    while (!(is_w ? w_ready : act_ready) && n < 200) begin step(); n++; end
    if (n >= 200) chk(is_w ? "w_ready_timeout" : "act_ready_timeout", 64'(n), 64'(0));
    step();
    w_valid   = 1'b0;
    act_valid = 1'b0;
  endtask

  task automatic run_job(input int k, input int s, input int np, input int maxgap,
                         input int hold, input bit chk_lat, input string tag);
    int start_cyc, n, len;
    logic [PSUM_BW*NUM_ROWS-1:0] snap;
    len = (NUM_ROWS - 1) * s + k;
    K = 3'(k); STRIDE = 2'(s); NUM_PASS = PASS_W'(np);
    core_start = 1'b1;
    start_cyc  = cyc;
    step();
    core_start = 1'b0;
    K = 3'($urandom); STRIDE = 2'($urandom); NUM_PASS = PASS_W'($urandom);
    chk({tag, "_busy_start"}, 64'(core_busy), 64'(1));
    for (int p = 0; p < np; p++) begin
      for (int kx = 0; kx < k; kx++) send(1'b1, wq[p][kx], $urandom_range(maxgap, 0));
      for (int x = 0; x < len; x++) send(1'b0, aq[p][x], $urandom_range(maxgap, 0));
    end
    n = 0;
    while (!psum_valid && n < 500) begin step(); n++; end
    chk({tag, "_psum_valid"}, 64'(psum_valid), 64'(1));
    if (chk_lat) chk({tag, "_latency"}, 64'(cyc - start_cyc), 64'(1 + np * (2 * k + len)));
    chk({tag, "_no_early_done"}, 64'(core_done), 64'(0));
    model(k, s, np);
    snap = psum_rows;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin core_start = 1'b1; K = 3'd0; end  // must be ignored outside idle
      step();
      core_start = 1'b0;
      chk({tag, "_hold_stable"}, 64'(psum_rows === snap), 64'(1));
      chk({tag, "_hold_valid"}, 64'(psum_valid), 64'(1));
      chk({tag, "_hold_done"}, 64'({core_done, err_cfg}), 64'(0));
    end
    psum_ready = 1'b1;
    step();
    psum_ready = 1'b0;
    chk({tag, "_done"}, 64'({core_done, err_cfg, psum_valid, core_busy}), 64'(4'b1001));
    for (int j = 0; j < NUM_ROWS; j++) chk({tag, "_lane"}, 64'(lane(j)), 64'(expv[j]));
    step();
    chk({tag, "_idle"}, 64'({core_done, core_busy}), 64'(0));
    chk({tag, "_rows_kept"}, 64'(psum_rows === snap), 64'(1));
  endtask

  initial begin
    int bad_k [5], bad_s [5], bad_np [5];
    logic [PSUM_BW*NUM_ROWS-1:0] snap;
    bad_k  = '{0, 4, 3, 3, 2};
    bad_s  = '{1, 1, 0, 3, 1};
    bad_np = '{1, 1, 1, 1, 0};
    resetn = 1'b0; core_start = 1'b0; K = '0; STRIDE = '0; NUM_PASS = '0;
    w_valid = 1'b0; act_valid = 1'b0; w_data = '0; act_data = '0; psum_ready = 1'b0;
    repeat (3) step();
    chk("reset_ctrl", 64'({core_busy, core_done, err_cfg, w_ready, act_ready, psum_valid}),
        64'(0));
    chk("reset_rows", 64'(psum_rows == '0), 64'(1));
    resetn = 1'b1;
    step();

    // T1: K=1, w=2, act[x]=x -> lane j = 2j
    wq[0][0] = 8'sd2;
    for (int x = 0; x < ACT_DEPTH; x++) aq[0][x] = 8'(x);
    run_job(1, 1, 1, 0, 0, 1'b1, "t1");
    chk("t1_lane7", 64'(lane(7)), 64'(14));

    // T2: all ones, K=3, 3 passes -> 9
    for (int p = 0; p < MAXP; p++) begin
      for (int kx = 0; kx < K_MAX; kx++) wq[p][kx] = 8'sd1;
      for (int x = 0; x < ACT_DEPTH; x++) aq[p][x] = 8'sd1;
    end
    run_job(3, 1, 3, 0, 0, 1'b1, "t2");
    chk("t2_lane5", 64'(lane(5)), 64'(9));

    // T3: K=3, S=2, w={1,0,-1}, act[x]=x -> -2
    wq[0][0] = 8'sd1; wq[0][1] = 8'sd0; wq[0][2] = -8'sd1;
    for (int x = 0; x < ACT_DEPTH; x++) aq[0][x] = 8'(x);
    run_job(3, 2, 1, 0, 0, 1'b1, "t3");
    chk("t3_lane0", 64'(lane(0)), 64'(32'hFFFF_FFFE));

    // T4: extreme negative operands over two passes -> 32768
    for (int p = 0; p < 2; p++) begin
      wq[p][0] = -8'sd128;
      for (int x = 0; x < ACT_DEPTH; x++) aq[p][x] = -8'sd128;
    end
    run_job(1, 1, 2, 0, 0, 1'b1, "t4");
    chk("t4_lane31", 64'(lane(31)), 64'(32768));

    // T5: random configs and data with bubbles and a stalled psum port
    for (int r = 0; r < 4; r++) begin
      int k, s, np;
      k = $urandom_range(K_MAX, 1); s = $urandom_range(STRIDE_MAX, 1); np = $urandom_range(3, 1);
      for (int p = 0; p < MAXP; p++) begin
        for (int kx = 0; kx < K_MAX; kx++) wq[p][kx] = 8'($urandom);
        for (int x = 0; x < ACT_DEPTH; x++) aq[p][x] = 8'($urandom);
      end
      run_job(k, s, np, 2, 10, 1'b0, "t5");
    end

    // T6: illegal configs -> error pulse, no streams, accumulators untouched
    for (int i = 0; i < 5; i++) begin
      snap = psum_rows;
      K = 3'(bad_k[i]); STRIDE = 2'(bad_s[i]); NUM_PASS = PASS_W'(bad_np[i]);
      core_start = 1'b1;
      step();
      core_start = 1'b0;
      chk("t6_err_pulse", 64'({core_done, err_cfg, core_busy}), 64'(3'b111));
      chk("t6_no_ready", 64'({w_ready, act_ready, psum_valid}), 64'(0));
      step();
      chk("t6_after", 64'({core_done, err_cfg, w_ready, act_ready, core_busy}), 64'(0));
      chk("t6_rows", 64'(psum_rows === snap), 64'(1));
    end

    // T7: reset in the middle of the activation load, then a clean T2 job
    for (int p = 0; p < MAXP; p++) begin
      for (int kx = 0; kx < K_MAX; kx++) wq[p][kx] = 8'sd1;
      for (int x = 0; x < ACT_DEPTH; x++) aq[p][x] = 8'sd1;
    end
    K = 3'd3; STRIDE = 2'd1; NUM_PASS = PASS_W'(3);
    core_start = 1'b1;
    step();
    core_start = 1'b0;
    for (int kx = 0; kx < 3; kx++) send(1'b1, 8'sd1, 0);
    for (int x = 0; x < 5; x++) send(1'b0, 8'sd1, 0);
    chk("t7_in_load_a", 64'(act_ready), 64'(1));
    #2 resetn = 1'b0;
    #1;
    chk("t7_async_ctrl", 64'({core_busy, core_done, err_cfg, w_ready, act_ready, psum_valid}),
        64'(0));
    chk("t7_async_rows", 64'(psum_rows == '0), 64'(1));
    step();
    step();
    resetn = 1'b1;
    step();
    run_job(3, 1, 3, 0, 0, 1'b1, "t7");
    chk("t7_lane31", 64'(lane(31)), 64'(9));

    chk("one_ready_at_a_time", 64'(overlap), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
